sprite_drawer: RTL and testbench

//  Consumer end of the sprite-frontend -> drawer request handshake. Accepts one draw

---
 rtl/sprite_drawer_if.sv | 26 ++
 rtl/sprite_drawer.sv | 116 +++++++++++
 tb/tb_sprite_drawer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_drawer_if.sv
// Drawer-side bundle: frontend request/done handshake, pattern-ROM read port, line-buffer write port.
interface sprite_drawer_if #(
  parameter int PIX_W = 8
);
  logic             draw_req;
  logic [9:0]       col_base;
  logic             flip;
  logic [7:0]       frame_id;
  logic [3:0]       row_off;
  logic             draw_done;
  logic [15:0]      rom_addr;
  logic [PIX_W-1:0] rom_data;
  logic             lb_we;
  logic [9:0]       lb_addr;
  logic [PIX_W-1:0] lb_data;

  modport slave (
    input  draw_req, col_base, flip, frame_id, row_off, rom_data,
    output draw_done, rom_addr, lb_we, lb_addr, lb_data
  );

  modport master (
    output draw_req, col_base, flip, frame_id, row_off, rom_data,
    input  draw_done, rom_addr, lb_we, lb_addr, lb_data
  );
endinterface

// File: rtl/sprite_drawer.sv
// Draws one 16-pixel sprite row slice into the line buffer: 18 clks busy per request, writes C2..C17,
// draw_req while busy is ignored; `SPRITE_TRANSP_EN suppresses writes of the TRANSP palette index.
module sprite_drawer #(
  parameter int SPR_W  = 16,
  parameter int PIX_W  = 8,
  parameter int LINE_W = 640,
  parameter int TRANSP = 0
) (
  input  logic          clk,
  input  logic          reset,
  sprite_drawer_if.slave bus
);

  localparam int PXW = $clog2(SPR_W);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [PXW-1:0]   px_q, px_d;
  logic [9:0]       col_q, col_d;
  logic             flip_q, flip_d;
  logic [7:0]       frame_q, frame_d;
  logic [3:0]       row_q, row_d;
  logic [15:0]      rom_addr_q, rom_addr_d;
  logic             valid_q, valid_d;
  logic [9:0]       dst_q, dst_d;
  logic             clip_q, clip_d;
  logic [10:0]      dst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      px_q       <= '0;
      col_q      <= '0;
      flip_q     <= 1'b0;
      frame_q    <= '0;
      row_q      <= '0;
      rom_addr_q <= '0;
      valid_q    <= 1'b0;
      dst_q      <= '0;
      clip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      col_q      <= col_d;
      flip_q     <= flip_d;
      frame_q    <= frame_d;
      row_q      <= row_d;
      rom_addr_q <= rom_addr_d;
      valid_q    <= valid_d;
      dst_q      <= dst_d;
      clip_q     <= clip_d;
    end
  end

  // 11-bit sum so a base near 1023 clips instead of wrapping to column 0
  always_comb begin
    dst = {1'b0, col_q} + (flip_q ? (11'(SPR_W - 1) - 11'(px_q)) : 11'(px_q));
  end

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    col_d      = col_q;
    flip_d     = flip_q;
    frame_d    = frame_q;
    row_d      = row_q;
    rom_addr_d = rom_addr_q;
    valid_d    = 1'b0;
    dst_d      = dst_q;
    clip_d     = clip_q;
    case (state_q)
      IDLE: begin
        if (bus.draw_req) begin
          col_d      = bus.col_base;
          flip_d     = bus.flip;
          frame_d    = bus.frame_id;
          row_d      = bus.row_off;
          px_d       = '0;
          rom_addr_d = 16'({bus.frame_id, bus.row_off, PXW'(0)});
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // rom_addr_q already points at px_q; stage its destination for the ROM return
        valid_d = 1'b1;
        dst_d   = dst[9:0];
        clip_d  = (dst >= 11'(LINE_W));
        if (px_q == PXW'(SPR_W - 1)) begin
          state_d = DRAIN;
        end else begin
          px_d       = px_q + PXW'(1);
          rom_addr_d = 16'({frame_q, row_q, px_q + PXW'(1)});
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.draw_done = (state_q == IDLE) & ~bus.draw_req;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.lb_addr   = dst_q;
  assign bus.lb_data   = bus.rom_data;

`ifdef SPRITE_TRANSP_EN
  assign bus.lb_we = valid_q & ~clip_q & (bus.rom_data != PIX_W'(TRANSP));
`else
  assign bus.lb_we = valid_q & ~clip_q;
`endif

endmodule

// File: tb/tb_sprite_drawer.sv
// Directed bench for sprite_drawer: expected line-buffer writes queued at request time, checked by a monitor.
module tb_sprite_drawer;

`ifdef SPRITE_TRANSP_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  bit   zero_mode = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   wr_cnt = 0;
  exp_t expq[$];

  sprite_drawer_if #(.PIX_W(8)) bus();

  sprite_drawer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_model(input logic [15:0] a, input bit z);
    if (z && a[3:0] >= 4'd4 && a[3:0] <= 4'd7) return 8'd0;
    return a[7:0] + 8'd1;
  endfunction

  always @(posedge clk) bus.rom_data <= rom_model(bus.rom_addr, zero_mode);

  task automatic check(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.draw_req) check("done_low_on_req", int'(bus.draw_done), 0);
    if (bus.lb_we) begin
      wr_cnt++;
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: col %0d data %0d at cycle %0d, none expected",
                 bus.lb_addr, bus.lb_data, cyc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_col", int'(bus.lb_addr), int'(e.addr));
        check("wr_data", int'(bus.lb_data), int'(e.data));
      end
    end
  end

  // Called at #1 after the edge that opens C0; returns at #1 into C1.
  task automatic issue_req(input int col, input bit flp, input int frm, input int row, input int npx);
    int          c0;
    int          d;
    logic [15:0] a;
    logic [7:0]  d8;
    exp_t        e;
    bus.draw_req = 1'b1;
    bus.col_base = 10'(col);
    bus.flip     = flp;
    bus.frame_id = 8'(frm);
    bus.row_off  = 4'(row);
    c0 = cyc;
    for (int px = 0; px < npx; px++) begin
      d  = col + (flp ? 15 - px : px);
      a  = {8'(frm), 4'(row), 4'(px)};
      d8 = rom_model(a, zero_mode);
      if (d < 640 && !(TR && d8 == 8'd0)) begin
        e.cyc  = c0 + 2 + px;
        e.addr = 10'(d);
        e.data = d8;
        expq.push_back(e);
      end
    end
    @(posedge clk); #1;
    bus.draw_req = 1'b0;
  endtask

  task automatic wait_idle(input int already, output int busy);
    bit seen;
    seen = 1'b0;
    busy = already;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.draw_done) begin
        seen = 1'b1;
        break;
      end
      busy++;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: draw_done still low after %0d cycles, expected high", busy);
    end
  endtask

  task automatic run_sprite(input string nm, input int col, input bit flp, input int frm,
                            input int row, input int exp_writes);
    int w0;
    int busy;
    @(posedge clk); #1;
    w0 = wr_cnt;
    issue_req(col, flp, frm, row, 16);
    wait_idle(1, busy);
    check({nm, "_busy"}, busy, 18);
    check({nm, "_writes"}, wr_cnt - w0, exp_writes);
  endtask

  initial begin
    int w0;
    int busy;
    reset        = 1'b1;
    bus.draw_req = 1'b0;
    bus.col_base = '0;
    bus.flip     = 1'b0;
    bus.frame_id = '0;
    bus.row_off  = '0;
    #12;
    check("rst_done", int'(bus.draw_done), 1);
    check("rst_we", int'(bus.lb_we), 0);
    check("rst_rom_addr", int'(bus.rom_addr), 0);
    check("rst_lb_addr", int'(bus.lb_addr), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_sprite("basic", 100, 1'b0, 3, 5, 16);
    run_sprite("flip", 100, 1'b1, 3, 5, 16);
    run_sprite("clip630", 630, 1'b0, 3, 5, 10);
    run_sprite("clip700", 700, 1'b0, 3, 5, 0);
    run_sprite("nowrap1020", 1020, 1'b0, 7, 9, 0);
    run_sprite("flipclip632", 632, 1'b1, 2, 1, 8);

    // Back-to-back: second request in C18 of the first
    @(posedge clk); #1;
    w0 = wr_cnt;
    issue_req(100, 1'b0, 3, 5, 16);
    repeat (17) @(posedge clk);
    #1;
    check("b2b_idle_c18", int'(bus.draw_done), 1);
    issue_req(200, 1'b1, 4, 2, 16);
    wait_idle(1, busy);
    check("b2b_busy", busy, 18);
    check("b2b_writes", wr_cnt - w0, 32);

    // Stray request pulse at C5 must be ignored
    @(posedge clk); #1;
    w0 = wr_cnt;
    issue_req(40, 1'b0, 6, 3, 16);
    repeat (4) @(posedge clk);
    #1;
    bus.draw_req = 1'b1;
    bus.col_base = 10'd300;
    bus.frame_id = 8'd9;
    bus.flip     = 1'b1;
    @(posedge clk); #1;
    bus.draw_req = 1'b0;
    wait_idle(6, busy);
    check("ignore_busy", busy, 18);
    check("ignore_writes", wr_cnt - w0, 16);

    // Async reset in the middle of C8: px0..5 already written, nothing afterwards
    @(posedge clk); #1;
    w0 = wr_cnt;
    issue_req(200, 1'b0, 3, 5, 6);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_we", int'(bus.lb_we), 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_done", int'(bus.draw_done), 1);
    check("midrst_rom_addr", int'(bus.rom_addr), 0);
    check("midrst_lb_addr", int'(bus.lb_addr), 0);
    repeat (20) @(posedge clk);
    check("midrst_writes", wr_cnt - w0, 6);

    // Transparent pixels 4..7
    zero_mode = 1'b1;
    run_sprite("transp", 50, 1'b0, 3, 5, TR ? 12 : 16);
    zero_mode = 1'b0;

    repeat (3) @(posedge clk);
    check("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
